// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and the datapath/memory side.
// master = controller, slave = datapath and memory interface.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op, bus_err
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op, bus_err
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle processor control FSM with memory-wait timeout.
// Optional macro CTRL_MUL_EN makes R-type funct 011000 (MUL, alucontrol 011) legal.
module mc_controller #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input logic            clk,
    input logic            reset_n,
    mc_controller_if.master bus
);

    localparam int unsigned CntW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluMul = 3'b011;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExecute, StAluWb, StBeqEx, StAddiEx, StAddiWb, StJex
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
`ifdef CTRL_MUL_EN
            6'b011000: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            6'b100010: a = AluSub;
            6'b100100: a = AluAnd;
            6'b100101: a = AluOr;
            6'b101010: a = AluSlt;
`ifdef CTRL_MUL_EN
            6'b011000: a = AluMul;
`endif
            default:   a = AluAdd;
        endcase
        return a;
    endfunction

    // State-only control word, loaded for the state being entered.
    function automatic ctrl_t moore_ctrl(input state_e s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_req    = 1'b1;
                c.alusrcb    = 2'b01;
                c.alucontrol = AluAdd;
            end
            StDecode: begin
                c.alusrcb    = 2'b11;
                c.alucontrol = AluAdd;
            end
            StMemAdr, StAddiEx: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = AluAdd;
            end
            StMemRd, StMemWr: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            StMemWb: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            StExecute: begin
                c.alusrca    = 1'b1;
                c.alucontrol = funct_alu(f);
            end
            StAluWb: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            StBeqEx: begin
                c.alusrca    = 1'b1;
                c.alucontrol = AluSub;
                c.pcsrc      = 2'b01;
            end
            StAddiWb: c.regwrite = 1'b1;
            StJex:    c.pcsrc    = 2'b10;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t           ctrl_q;

    logic in_mem, limit_hit, timeout, decode_illegal;

    assign in_mem    = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign limit_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == CntW'(WAIT_LIMIT - 1));
    // mem_ready in the limit cycle wins over the timeout.
    assign timeout   = in_mem && !bus.mem_ready && limit_hit;

    always_comb begin
        decode_illegal = 1'b0;
        case (bus.op)
            OpLw, OpSw, OpBeq, OpAddi, OpJ: decode_illegal = 1'b0;
            OpRtype:                        decode_illegal = !funct_legal(bus.funct);
            default:                        decode_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        if (timeout) begin
            state_d = StFetch;
        end else if (in_mem && !bus.mem_ready) begin
            if (WAIT_LIMIT != 0) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                StFetch:   state_d = StDecode;
                StDecode: begin
                    if (decode_illegal) begin
                        state_d = StFetch;
                    end else begin
                        case (bus.op)
                            OpLw, OpSw: state_d = StMemAdr;
                            OpRtype:    state_d = StExecute;
                            OpBeq:      state_d = StBeqEx;
                            OpAddi:     state_d = StAddiEx;
                            default:    state_d = StJex;
                        endcase
                    end
                end
                StMemAdr:  state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
                StMemRd:   state_d = StMemWb;
                StExecute: state_d = StAluWb;
                StAddiEx:  state_d = StAddiWb;
                default:   state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            ctrl_q     <= moore_ctrl(StFetch, 6'b000000);
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= moore_ctrl(state_d, bus.funct);
        end
    end

    // Outputs are gated by reset_n so strobes drop in the same cycle reset asserts.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcen       = 1'b0;
        bus.alucontrol = 3'b000;
        bus.illegal_op = 1'b0;
        bus.bus_err    = 1'b0;
        if (reset_n) begin
            bus.mem_req    = ctrl_q.mem_req;
            bus.iord       = ctrl_q.iord;
            bus.regdst     = ctrl_q.regdst;
            bus.memtoreg   = ctrl_q.memtoreg;
            bus.regwrite   = ctrl_q.regwrite;
            bus.alusrca    = ctrl_q.alusrca;
            bus.alusrcb    = ctrl_q.alusrcb;
            bus.pcsrc      = ctrl_q.pcsrc;
            bus.alucontrol = ctrl_q.alucontrol;
            bus.memwrite   = (state_q == StMemWr) && bus.mem_ready;
            bus.irwrite    = (state_q == StFetch) && bus.mem_ready;
            bus.pcen       = ((state_q == StFetch) && bus.mem_ready)
                           || (state_q == StJex)
                           || ((state_q == StBeqEx) && bus.zero);
            bus.illegal_op = (state_q == StDecode) && decode_illegal;
            bus.bus_err    = timeout;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction table plus hand-written wait/timeout/reset
// sequences, with expected control words queued per cycle and compared at the falling edge.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller #(.WAIT_LIMIT(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] sb[$];

    logic [17:0] act;
    assign act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.regdst, bus.memtoreg,
                  bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol,
                  bus.illegal_op, bus.bus_err};

    function automatic logic [17:0] w(input logic mreq, input logic mwr, input logic iord,
                                      input logic irw, input logic rdst, input logic m2r,
                                      input logic rw, input logic asa, input logic [1:0] asb,
                                      input logic [1:0] psrc, input logic pcen,
                                      input logic [2:0] alu, input logic ill, input logic berr);
        return {mreq, mwr, iord, irw, rdst, m2r, rw, asa, asb, psrc, pcen, alu, ill, berr};
    endfunction

    typedef struct {
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             zero;
        int               n;
        logic [4:0][17:0] exp;
    } vec_t;

    vec_t vecs[14];

    logic [17:0] e_frdy, e_fwait, e_ferr, e_dec, e_dill, e_aluwb, e_memadr, e_memrd, e_memwb;
    logic [17:0] e_wrrdy, e_wrerr, e_beq1, e_beq0, e_addiex, e_addiwb, e_jex;

    function automatic logic [17:0] e_exe(input logic [2:0] alu);
        return w(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, alu, 0, 0);
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                                input int n, input logic [17:0] e0, input logic [17:0] e1,
                                input logic [17:0] e2, input logic [17:0] e3,
                                input logic [17:0] e4);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.n = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    task automatic check(input string name);
        logic [17:0] e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", name, act, e);
            end
        end
    endtask

    // Called just after a rising edge; checks the cycle at the falling edge.
    task automatic step(input string name, input logic [17:0] e);
        sb.push_back(e);
        @(negedge clk);
        check(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_frdy   = w(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3'b010, 0, 0);
        e_fwait  = w(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 3'b010, 0, 0);
        e_ferr   = w(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 3'b010, 0, 1);
        e_dec    = w(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0);
        e_dill   = w(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 1, 0);
        e_aluwb  = w(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e_memadr = w(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0);
        e_memrd  = w(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e_memwb  = w(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e_wrrdy  = w(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e_wrerr  = w(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 1);
        e_beq1   = w(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 3'b110, 0, 0);
        e_beq0   = w(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 3'b110, 0, 0);
        e_addiex = w(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0);
        e_addiwb = w(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e_jex    = w(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b000, 0, 0);

        vecs[0]  = mk(6'b000000, 6'b100000, 0, 4, e_frdy, e_dec, e_exe(3'b010), e_aluwb, 0);
        vecs[1]  = mk(6'b000000, 6'b100010, 0, 4, e_frdy, e_dec, e_exe(3'b110), e_aluwb, 0);
        vecs[2]  = mk(6'b000000, 6'b100100, 1, 4, e_frdy, e_dec, e_exe(3'b000), e_aluwb, 0);
        vecs[3]  = mk(6'b000000, 6'b100101, 0, 4, e_frdy, e_dec, e_exe(3'b001), e_aluwb, 0);
        vecs[4]  = mk(6'b000000, 6'b101010, 0, 4, e_frdy, e_dec, e_exe(3'b111), e_aluwb, 0);
        vecs[5]  = mk(6'b100011, 6'b000000, 0, 5, e_frdy, e_dec, e_memadr, e_memrd, e_memwb);
        vecs[6]  = mk(6'b101011, 6'b000000, 0, 4, e_frdy, e_dec, e_memadr, e_wrrdy, 0);
        vecs[7]  = mk(6'b000100, 6'b000000, 1, 3, e_frdy, e_dec, e_beq1, 0, 0);
        vecs[8]  = mk(6'b000100, 6'b000000, 0, 3, e_frdy, e_dec, e_beq0, 0, 0);
        vecs[9]  = mk(6'b001000, 6'b000000, 0, 4, e_frdy, e_dec, e_addiex, e_addiwb, 0);
        vecs[10] = mk(6'b000010, 6'b000000, 0, 3, e_frdy, e_dec, e_jex, 0, 0);
        vecs[11] = mk(6'b111111, 6'b100000, 0, 2, e_frdy, e_dill, 0, 0, 0);
`ifdef CTRL_MUL_EN
        vecs[12] = mk(6'b000000, 6'b011000, 0, 4, e_frdy, e_dec, e_exe(3'b011), e_aluwb, 0);
`else
        vecs[12] = mk(6'b000000, 6'b011000, 0, 2, e_frdy, e_dill, 0, 0, 0);
`endif
        vecs[13] = mk(6'b000000, 6'b000001, 0, 2, e_frdy, e_dill, 0, 0, 0);

        bus.op = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        sb.push_back('0);
        @(negedge clk);
        check("reset_outputs");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            bus.op = vecs[i].op; bus.funct = vecs[i].funct; bus.zero = vecs[i].zero;
            for (int c = 0; c < vecs[i].n; c++) begin
                step($sformatf("vec%0d_c%0d", i, c), vecs[i].exp[c]);
            end
        end

        // lw with three wait cycles in MEMRD; ready arrives right at the limit count.
        bus.op = 6'b100011; bus.funct = 6'b000000; bus.zero = 1'b0;
        step("lw_fetch", e_frdy);
        step("lw_dec", e_dec);
        bus.mem_ready = 1'b0;
        step("lw_memadr", e_memadr);
        for (int k = 0; k < 3; k++) step($sformatf("lw_memrd_wait%0d", k), e_memrd);
        bus.mem_ready = 1'b1;
        step("lw_memrd_ready", e_memrd);
        step("lw_memwb", e_memwb);

        // FETCH timeout, then a second wait that completes exactly at the limit.
        bus.op = 6'b000010;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step($sformatf("fetch_wait%0d", k), e_fwait);
        step("fetch_bus_err", e_ferr);
        for (int k = 0; k < 3; k++) step($sformatf("fetch_rewait%0d", k), e_fwait);
        bus.mem_ready = 1'b1;
        step("fetch_limit_ready", e_frdy);
        step("j_dec", e_dec);
        step("j_jex", e_jex);

        // MEMWR timeout returns to FETCH with no memwrite.
        bus.op = 6'b101011;
        step("swto_fetch", e_frdy);
        step("swto_dec", e_dec);
        bus.mem_ready = 1'b0;
        step("swto_memadr", e_memadr);
        for (int k = 0; k < 3; k++) step($sformatf("swto_wait%0d", k), e_memrd);
        step("swto_bus_err", e_wrerr);
        bus.op = 6'b000010;
        bus.mem_ready = 1'b1;
        step("swto_refetch", e_frdy);
        step("swto_j_dec", e_dec);
        step("swto_j_jex", e_jex);

        // Asynchronous reset while MEMWR is strobing.
        bus.op = 6'b101011;
        step("rst_fetch", e_frdy);
        step("rst_dec", e_dec);
        step("rst_memadr", e_memadr);
        #2;
        sb.push_back(e_wrrdy);
        check("rst_memwr_before");
        reset_n = 1'b0;
        #1;
        sb.push_back('0);
        check("rst_memwr_dropped");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.op = 6'b000010;
        step("rst_refetch", e_frdy);
        step("rst_j_dec", e_dec);
        step("rst_j_jex", e_jex);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
